// File: rtl/conv3x3_engine_pkg.sv
// rtl/conv3x3_engine_pkg.sv - shared widths, FSM states and helpers for the 3x3 convolution engine
package conv_pkg;

   localparam int PIX_W = 8;
   localparam int WGT_W = 8;
   localparam int ACC_W = 32;
   localparam int KSIZE = 3;
   localparam int KTAPS = KSIZE * KSIZE;

   typedef enum logic {
      ST_MAC,
      ST_EMIT
   } conv_state_t;

   // Negative sums are rectified to zero, large sums saturate at full scale.
   function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] acc);
      if (acc < 0)
         return '0;
      else if (acc > 255)
         return 8'hFF;
      else
         return acc[PIX_W-1:0];
   endfunction

   function automatic int pix_index(input int c, input int y, input int x,
                                    input int width, input int height);
      return (c * height + y) * width + x;
   endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// rtl/conv3x3_engine_if.sv - feature map, kernel and result strobe bus of the convolution engine
interface conv3x3_engine_if #(
   parameter int WIDTH   = 3,
   parameter int HEIGHT  = 3,
   parameter int CHANNEL = 1
);
   import conv_pkg::*;

   logic [PIX_W*WIDTH*HEIGHT*CHANNEL-1:0] indata;
   logic [WGT_W*KTAPS-1:0]                filterWeight;
   logic [PIX_W-1:0]                      result;
   logic [7:0]                            res_address;
   logic                                  dataready;

   modport master (
      output indata, filterWeight,
      input  result, res_address, dataready
   );

   modport slave (
      input  indata, filterWeight,
      output result, res_address, dataready
   );

endinterface

// File: rtl/conv3x3_engine_mac.sv
// rtl/conv3x3_engine_mac.sv - signed multiply-accumulate of an unsigned pixel and a signed weight
module conv_mac_unit
   import conv_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic [PIX_W-1:0]        pix,
   input  logic signed [WGT_W-1:0] wgt,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [PIX_W+WGT_W:0] prod;

   // Pixel is zero-extended by one bit so the product stays a true signed multiply.
   assign prod = $signed({1'b0, pix}) * wgt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + ACC_W'(prod);
   end

endmodule

// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - free-running zero-padded 3x3 convolution, one product per clock
module conv3x3_engine
   import conv_pkg::*;
#(
   parameter int WIDTH   = 3,
   parameter int HEIGHT  = 3,
   parameter int CHANNEL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   conv3x3_engine_if.slave  bus
);

   localparam int NPOS      = WIDTH * HEIGHT;
   localparam int NPIX      = NPOS * CHANNEL;
   localparam int PIX_IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int CH_W      = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

   conv_state_t             state;
   logic [7:0]              pos;
   logic [7:0]              px;
   logic [7:0]              py;
   logic [1:0]              kx;
   logic [1:0]              ky;
   logic [3:0]              tap;
   logic [CH_W-1:0]         ch;
   logic [WGT_W*KTAPS-1:0]  w_reg;
   logic [PIX_W-1:0]        result_q;
   logic [7:0]              addr_q;
   logic                    ready_q;
   logic signed [ACC_W-1:0] acc;
   logic                    first_cycle;
   logic [PIX_W-1:0]        mac_pix;
   logic signed [WGT_W-1:0] mac_wgt;

   logic [PIX_W-1:0]        pix_arr  [NPIX];
   logic signed [WGT_W-1:0] wgt_live [KTAPS];
   logic signed [WGT_W-1:0] wgt_lat  [KTAPS];

   for (genvar i = 0; i < NPIX; i++) begin : g_pix
      assign pix_arr[i] = bus.indata[PIX_W*i +: PIX_W];
   end

   for (genvar k = 0; k < KTAPS; k++) begin : g_wgt
      assign wgt_live[k] = bus.filterWeight[WGT_W*k +: WGT_W];
      assign wgt_lat[k]  = w_reg[WGT_W*k +: WGT_W];
   end

   assign first_cycle = (state == ST_MAC) && (pos == 8'd0) && (tap == 4'd0) && (ch == '0);

   // On the latching cycle the register is not yet loaded, so tap 0 uses the live bus.
   assign mac_wgt = first_cycle ? wgt_live[tap] : wgt_lat[tap];

   always_comb begin
      int iy;
      int ix;
      int idx;
      mac_pix = '0;
      iy  = int'(py) + int'(ky) - 1;
      ix  = int'(px) + int'(kx) - 1;
      idx = pix_index(int'(ch), iy, ix, WIDTH, HEIGHT);
      if (iy >= 0 && iy < HEIGHT && ix >= 0 && ix < WIDTH)
         mac_pix = pix_arr[PIX_IDX_W'(idx)];
   end

   conv_mac_unit u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == ST_EMIT),
      .en    (state == ST_MAC),
      .pix   (mac_pix),
      .wgt   (mac_wgt),
      .acc   (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_MAC;
         pos      <= '0;
         px       <= '0;
         py       <= '0;
         kx       <= '0;
         ky       <= '0;
         tap      <= '0;
         ch       <= '0;
         w_reg    <= '0;
         result_q <= '0;
         addr_q   <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state)
            ST_MAC: begin
               if (first_cycle)
                  w_reg <= bus.filterWeight;
               if (kx == 2'd2) begin
                  kx <= '0;
                  ky <= (ky == 2'd2) ? 2'd0 : ky + 2'd1;
               end else begin
                  kx <= kx + 2'd1;
               end
               if (tap == 4'(KTAPS - 1)) begin
                  tap <= '0;
                  if (ch == CH_W'(CHANNEL - 1)) begin
                     ch    <= '0;
                     state <= ST_EMIT;
                  end else begin
                     ch <= ch + CH_W'(1);
                  end
               end else begin
                  tap <= tap + 4'd1;
               end
            end
            ST_EMIT: begin
               result_q <= clamp_pix(acc);
               addr_q   <= pos;
               ready_q  <= 1'b1;
               state    <= ST_MAC;
               if (pos == 8'(NPOS - 1)) begin
                  pos <= '0;
                  px  <= '0;
                  py  <= '0;
               end else begin
                  pos <= pos + 8'd1;
                  if (px == 8'(WIDTH - 1)) begin
                     px <= '0;
                     py <= py + 8'd1;
                  end else begin
                     px <= px + 8'd1;
                  end
               end
            end
            default: state <= ST_MAC;
         endcase
      end
   end

   assign bus.result      = result_q;
   assign bus.res_address = addr_q;
   assign bus.dataready   = ready_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb/tb_conv3x3_engine.sv - randomized and directed checks of conv3x3_engine against a reference model
module tb_conv3x3_engine;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   last_cyc [2];
   int   pm [2][3][4];
   int   wm [9];
   int   exp_old [12];
   int   exp_new [12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv3x3_engine_if #(.WIDTH(3), .HEIGHT(3), .CHANNEL(1)) ifa ();
   conv3x3_engine_if #(.WIDTH(4), .HEIGHT(3), .CHANNEL(2)) ifb ();

   conv3x3_engine #(.WIDTH(3), .HEIGHT(3), .CHANNEL(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_a),
      .bus   (ifa)
   );

   conv3x3_engine #(.WIDTH(4), .HEIGHT(3), .CHANNEL(2)) dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (ifb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Direct sum over the 3x3 neighbourhood of every channel, outside-map pixels count as zero.
   function automatic int model(input int w, input int h, input int c, input int p);
      int y = p / w;
      int x = p % w;
      int s = 0;
      for (int ci = 0; ci < c; ci++)
         for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
               if (y + dy >= 0 && y + dy < h && x + dx >= 0 && x + dx < w)
                  s += pm[ci][y+dy][x+dx] * wm[(dy+1)*3 + dx + 1];
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   task automatic apply_a();
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++)
            ifa.indata[8*(y*3+x) +: 8] = 8'(pm[0][y][x]);
      for (int k = 0; k < 9; k++)
         ifa.filterWeight[8*k +: 8] = 8'(wm[k]);
   endtask

   task automatic apply_b();
      for (int c = 0; c < 2; c++)
         for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
               ifb.indata[8*((c*3+y)*4+x) +: 8] = 8'(pm[c][y][x]);
      for (int k = 0; k < 9; k++)
         ifb.filterWeight[8*k +: 8] = 8'(wm[k]);
   endtask

   task automatic fill(input int pix_lo, input int pix_hi, input int w_lo, input int w_hi);
      for (int c = 0; c < 2; c++)
         for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
               pm[c][y][x] = int'($urandom_range(pix_hi - pix_lo)) + pix_lo;
      for (int k = 0; k < 9; k++)
         wm[k] = int'($urandom_range(w_hi - w_lo)) + w_lo;
   endtask

   task automatic do_reset(input int sel);
      @(negedge clk);
      if (sel == 1) rst_b = 1'b0; else rst_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (sel == 1) rst_b = 1'b1; else rst_a = 1'b1;
      last_cyc[sel] = cyc;
   endtask

   // Waits for the next strobe, then checks address, value and spacing from the previous strobe.
   task automatic expect_out(input int sel, input int addr, input int val);
      int   n = 0;
      logic rdy;
      @(negedge clk);
      rdy = (sel == 1) ? ifb.dataready : ifa.dataready;
      while (!rdy && n < 64) begin
         @(negedge clk);
         n++;
         rdy = (sel == 1) ? ifb.dataready : ifa.dataready;
      end
      check((sel == 1) ? "b_strobe" : "a_strobe", 32'(rdy), 1);
      if (rdy) begin
         check((sel == 1) ? "b_addr" : "a_addr",
               (sel == 1) ? 32'(ifb.res_address) : 32'(ifa.res_address), 32'(addr));
         check((sel == 1) ? "b_result" : "a_result",
               (sel == 1) ? 32'(ifb.result) : 32'(ifa.result), 32'(val));
         check((sel == 1) ? "b_period" : "a_period", 32'(cyc - last_cyc[sel]),
               (sel == 1) ? 32'd19 : 32'd10);
         last_cyc[sel] = cyc;
      end
   endtask

   initial begin
      int ones_a [9];
      int ones_b [12];
      ones_a = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
      ones_b = '{12, 18, 18, 12, 18, 27, 27, 18, 12, 18, 18, 12};

      for (int c = 0; c < 2; c++)
         for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
               pm[c][y][x] = 1;
      for (int k = 0; k < 9; k++) wm[k] = 1;
      apply_a();
      apply_b();
      repeat (3) @(negedge clk);
      check("rst_result", 32'(ifa.result), 0);
      check("rst_addr", 32'(ifa.res_address), 0);
      check("rst_ready", 32'(ifa.dataready), 0);
      rst_a = 1'b1;
      last_cyc[0] = cyc;
      for (int p = 0; p < 9; p++) expect_out(0, p, ones_a[p]);

      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++)
            pm[0][y][x] = y * 3 + x;
      for (int k = 0; k < 9; k++) wm[k] = (k == 4) ? 1 : 0;
      apply_a();
      do_reset(0);
      for (int p = 0; p < 9; p++) expect_out(0, p, p);
      expect_out(0, 0, 0);

      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++)
            pm[0][y][x] = 255;
      for (int k = 0; k < 9; k++) wm[k] = 1;
      apply_a();
      do_reset(0);
      for (int p = 0; p < 9; p++) expect_out(0, p, 255);

      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++)
            pm[0][y][x] = 5;
      for (int k = 0; k < 9; k++) wm[k] = -1;
      apply_a();
      do_reset(0);
      for (int p = 0; p < 9; p++) expect_out(0, p, 0);

      for (int it = 0; it < 4; it++) begin
         if (it == 0) fill(0, 255, -128, 127);
         else fill(0, 40, -3, 4);
         apply_a();
         do_reset(0);
         for (int p = 0; p < 9; p++) expect_out(0, p, model(3, 3, 1, p));
      end

      fill(1, 5, 0, 2);
      apply_a();
      do_reset(0);
      for (int p = 0; p < 9; p++) exp_old[p] = model(3, 3, 1, p);
      for (int k = 0; k < 9; k++) wm[k] = wm[k] + 2;
      for (int p = 0; p < 9; p++) exp_new[p] = model(3, 3, 1, p);
      for (int p = 0; p < 4; p++) expect_out(0, p, exp_old[p]);
      apply_a();
      for (int p = 4; p < 9; p++) expect_out(0, p, exp_old[p]);
      for (int p = 0; p < 9; p++) expect_out(0, p, exp_new[p]);

      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++)
            pm[0][y][x] = 1;
      for (int k = 0; k < 9; k++) wm[k] = 1;
      apply_a();
      do_reset(0);
      for (int p = 0; p < 4; p++) expect_out(0, p, ones_a[p]);
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      #1;
      check("abort_result", 32'(ifa.result), 0);
      check("abort_addr", 32'(ifa.res_address), 0);
      check("abort_ready", 32'(ifa.dataready), 0);
      for (int k = 0; k < 9; k++) wm[k] = 2;
      apply_a();
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b1;
      last_cyc[0] = cyc;
      expect_out(0, 0, 8);
      expect_out(0, 1, 12);

      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++) begin
            pm[0][y][x] = 1;
            pm[1][y][x] = 2;
         end
      for (int k = 0; k < 9; k++) wm[k] = 1;
      apply_b();
      rst_b = 1'b1;
      last_cyc[1] = cyc;
      for (int p = 0; p < 12; p++) expect_out(1, p, ones_b[p]);

      for (int it = 0; it < 3; it++) begin
         if (it == 0) fill(0, 255, -128, 127);
         else fill(0, 25, -3, 4);
         apply_b();
         do_reset(1);
         for (int p = 0; p < 12; p++) expect_out(1, p, model(4, 3, 2, p));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", tests);
      $fatal(1);
   end

endmodule
